pc_fetch_ctrl: RTL and testbench

Parametrised program-counter and fetch-request generator: successor to the current fixed 64-bit PC register. Holds the fetch address, advances it by a fixed instruction step on each accepted instruction-memory request, accepts branch/jump redirects and stalls, and optionally predicts returns with a small return-address stack. Sits between the decode/branch logic and the instruction-memory port.

---
 rtl/pc_fetch_ctrl_pkg.sv | 16 +
 rtl/pc_fetch_ctrl_if.sv | 26 ++
 rtl/pc_fetch_ctrl_ras.sv | 57 +++++
 rtl/pc_fetch_ctrl.sv | 93 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and FSM state type for the fetch controller.
// Optional return-address stack is enabled by defining PC_FETCH_RAS_EN.
package pc_pkg;

    localparam int unsigned ANCHO_DEF     = 64;
    localparam int unsigned PASO_DEF      = 4;
    localparam logic [63:0] RESET_VEC_DEF = 64'h0;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle: redirect/stall controls in, instruction-memory request out.
// master = fetch controller, slave = decode/branch logic plus instruction memory.
interface pc_fetch_ctrl_if #(
    parameter int unsigned ANCHO = pc_pkg::ANCHO_DEF
);
    logic             stall;
    logic             branch_valid;
    logic [ANCHO-1:0] branch_target;
    logic             call;
    logic             ret;
    logic             fetch_ready;
    logic             fetch_valid;
    logic [ANCHO-1:0] fetch_addr;
    logic [ANCHO-1:0] pc_actual;
    logic             ras_empty;

    modport master (
        input  stall, branch_valid, branch_target, call, ret, fetch_ready,
        output fetch_valid, fetch_addr, pc_actual, ras_empty
    );

    modport slave (
        output stall, branch_valid, branch_target, call, ret, fetch_ready,
        input  fetch_valid, fetch_addr, pc_actual, ras_empty
    );
endinterface

// File: rtl/pc_fetch_ctrl_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Only instantiated when PC_FETCH_RAS_EN is defined.
module ras_stack #(
    parameter int unsigned W     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] top_idx;
    logic [PW:0]   cnt_q, cnt_d;

    // ptr_q is the next write slot; it wraps so the oldest entry is reused
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            if (cnt_q != DEPTH_C)
                cnt_d = cnt_q + 1'b1;
        end else if (pop && cnt_q != '0) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[ptr_q] <= push_data;
    end

    assign top_idx = ptr_q - 1'b1;
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch-request generator with redirect/stall handling.
// Define PC_FETCH_RAS_EN to add return prediction through ras_stack.
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int unsigned      ANCHO     = ANCHO_DEF,
    parameter int unsigned      PASO      = PASO_DEF,
    parameter logic [ANCHO-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_ctrl_if.master bus
);
    fetch_state_e     state_q, state_d;
    logic [ANCHO-1:0] pc_q, pc_d;
    logic [ANCHO-1:0] pc_act_q, pc_act_d;
    logic [ANCHO-1:0] redirect_tgt;
    logic             accept;

    assign accept = (state_q == RUN) && bus.fetch_ready;

`ifdef PC_FETCH_RAS_EN
    logic             ras_push, ras_pop, ras_empty_w, ras_full_unused;
    logic [ANCHO-1:0] ras_top;

    // call wins over ret; an empty stack falls back to branch_target
    assign ras_push = bus.branch_valid && bus.call;
    assign ras_pop  = bus.branch_valid && bus.ret && !bus.call && !ras_empty_w;

    ras_stack #(
        .W     (ANCHO),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_act_d + ANCHO'(PASO)),
        .top       (ras_top),
        .empty     (ras_empty_w),
        .full      (ras_full_unused)
    );

    assign redirect_tgt  = ras_pop ? ras_top : bus.branch_target;
    assign bus.ras_empty = ras_empty_w;
`else
    logic                 unused_ras_qual;
    logic [RAS_DEPTH-1:0] unused_ras_cfg;

    assign unused_ras_qual = bus.call ^ bus.ret;
    assign unused_ras_cfg  = '0;
    assign redirect_tgt    = bus.branch_target;
    assign bus.ras_empty   = 1'b1;
`endif

    // Priority: redirect > stall > handshake; a stall suppresses acceptance
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_act_d = pc_act_q;
        if (bus.branch_valid) begin
            if (accept)
                pc_act_d = pc_q;
            pc_d    = redirect_tgt;
            state_d = RUN;
        end else if (bus.stall) begin
            state_d = HOLD;
        end else begin
            state_d = RUN;
            if (accept) begin
                pc_act_d = pc_q;
                pc_d     = pc_q + ANCHO'(PASO);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RESET;
            pc_q     <= RESET_VEC;
            pc_act_q <= RESET_VEC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_act_q <= pc_act_d;
        end
    end

    assign bus.fetch_valid = (state_q == RUN);
    assign bus.fetch_addr  = pc_q;
    assign bus.pc_actual   = pc_act_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl; follows PC_FETCH_RAS_EN when defined.
module tb_pc_fetch_ctrl;
    import pc_pkg::*;

    localparam int unsigned AW    = 64;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 4;
`ifdef PC_FETCH_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [AW-1:0] act;
        logic          emp;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.ANCHO(AW)) bus ();

    pc_fetch_ctrl #(
        .ANCHO     (AW),
        .PASO      (STEP),
        .RESET_VEC (64'h0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    logic [AW-1:0] m_pc, m_act;
    logic          m_vld;
    logic [AW-1:0] m_ras[$];

    task automatic check_val(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_act = '0;
        m_vld = 1'b0;
        m_ras.delete();
    endtask

    function automatic obs_t model_now();
        obs_t o;
        o.vld  = m_vld;
        o.addr = m_pc;
        o.act  = m_act;
        o.emp  = RAS_ON ? (m_ras.size() == 0) : 1'b1;
        return o;
    endfunction

    task automatic model_step(input logic st, input logic bv, input logic [AW-1:0] tgt,
                              input logic cl, input logic rt, input logic rdy);
        logic          acc;
        logic [AW-1:0] nact;
        acc = m_vld && rdy;
        if (bv) begin
            nact = acc ? m_pc : m_act;
            if (RAS_ON && rt && !cl && m_ras.size() > 0)
                m_pc = m_ras.pop_back();
            else
                m_pc = tgt;
            if (RAS_ON && cl) begin
                m_ras.push_back(nact + AW'(STEP));
                if (m_ras.size() > DEPTH)
                    void'(m_ras.pop_front());
            end
            m_act = nact;
            m_vld = 1'b1;
        end else if (st) begin
            m_vld = 1'b0;
        end else begin
            if (acc) begin
                m_act = m_pc;
                m_pc  = m_pc + AW'(STEP);
            end
            m_vld = 1'b1;
        end
    endtask

    // Called 1 time unit after a rising edge; compares 1 unit after the next one
    task automatic step(input logic st, input logic bv, input logic [AW-1:0] tgt,
                        input logic cl, input logic rt, input logic rdy);
        obs_t e;
        bus.stall         = st;
        bus.branch_valid  = bv;
        bus.branch_target = tgt;
        bus.call          = cl;
        bus.ret           = rt;
        bus.fetch_ready   = rdy;
        model_step(st, bv, tgt, cl, rt, rdy);
        sb.push_back(model_now());
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_val("sb_vld",  AW'(bus.fetch_valid), AW'(e.vld));
        check_val("sb_addr", bus.fetch_addr,       e.addr);
        check_val("sb_act",  bus.pc_actual,        e.act);
        check_val("sb_emp",  AW'(bus.ras_empty),   AW'(e.emp));
    endtask

    task automatic go(input logic rdy);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);
    endtask

    task automatic br(input logic [AW-1:0] tgt, input logic rdy);
        step(1'b0, 1'b1, tgt, 1'b0, 1'b0, rdy);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_vld"},  AW'(bus.fetch_valid), '0);
        check_val({tag, "_addr"}, bus.fetch_addr,       '0);
        check_val({tag, "_act"},  bus.pc_actual,        '0);
        check_val({tag, "_emp"},  AW'(bus.ras_empty),   AW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall         = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_target = '0;
        bus.call          = 1'b0;
        bus.ret           = 1'b0;
        bus.fetch_ready   = 1'b0;
        model_reset();
        #2;
        check_reset_state("rst0");
        rst = 1'b0;

        // Sequential fetch from the reset vector
        go(1'b1);
        check_val("first_addr", bus.fetch_addr, 64'h0);
        check_val("first_vld", AW'(bus.fetch_valid), AW'(1));
        go(1'b1);
        check_val("seq_addr4", bus.fetch_addr, 64'h4);
        check_val("seq_act0", bus.pc_actual, 64'h0);
        go(1'b1);
        check_val("seq_addr8", bus.fetch_addr, 64'h8);

        // Backpressure holds the address
        go(1'b0);
        go(1'b0);
        go(1'b0);
        check_val("hold_addr8", bus.fetch_addr, 64'h8);
        check_val("hold_vld", AW'(bus.fetch_valid), AW'(1));
        go(1'b1);
        check_val("rel_addrC", bus.fetch_addr, 64'hC);
        go(1'b1);

        // Redirect cancels the pending 0x10
        br(64'h100, 1'b0);
        check_val("br_addr", bus.fetch_addr, 64'h100);
        check_val("br_act", bus.pc_actual, 64'hC);

        // Stall then stall+branch
        br(64'h20, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_val("stall_vld", AW'(bus.fetch_valid), '0);
        check_val("stall_addr", bus.fetch_addr, 64'h20);
        go(1'b0);
        check_val("unstall_vld", AW'(bus.fetch_valid), AW'(1));
        step(1'b1, 1'b1, 64'h40, 1'b0, 1'b0, 1'b0);
        check_val("stallbr_addr", bus.fetch_addr, 64'h40);

        // Call/return
        br(64'h30, 1'b0);
        step(1'b0, 1'b1, 64'h200, 1'b1, 1'b0, 1'b1);
        check_val("call_act", bus.pc_actual, 64'h30);
        check_val("call_addr", bus.fetch_addr, 64'h200);
        step(1'b0, 1'b1, 64'h999, 1'b0, 1'b1, 1'b0);
        check_val("ret_addr", bus.fetch_addr, RAS_ON ? 64'h34 : 64'h999);

        // Overflow: 5 calls into 4 entries, then 5 returns
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 64'h1000 + AW'(i) * 64'h100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 64'hABC0, 1'b0, 1'b1, 1'b1);
        check_val("ret4_addr", bus.fetch_addr, RAS_ON ? 64'h1004 : 64'hABC0);
        step(1'b0, 1'b1, 64'hABC0, 1'b0, 1'b1, 1'b1);
        check_val("ret5_addr", bus.fetch_addr, 64'hABC0);
        check_val("ret5_emp", AW'(bus.ras_empty), AW'(1));

        // call and ret together behave as a call
        step(1'b0, 1'b1, 64'h300, 1'b1, 1'b1, 1'b0);
        check_val("callret_addr", bus.fetch_addr, 64'h300);

        // Random mix
        for (int i = 0; i < 60; i++) begin
            logic          r_st, r_bv, r_cl, r_rt, r_rdy;
            logic [AW-1:0] r_tgt;
            r_st  = ($urandom_range(0, 4) == 0);
            r_bv  = ($urandom_range(0, 3) == 0);
            r_cl  = ($urandom_range(0, 2) == 0);
            r_rt  = ($urandom_range(0, 2) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_tgt = {$urandom(), $urandom()} & ~64'h3;
            step(r_st, r_bv, r_tgt, r_cl, r_rt, r_rdy);
        end

        // Address wrap
        br(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        go(1'b1);
        check_val("wrap_addr", bus.fetch_addr, 64'h0);
        check_val("wrap_act", bus.pc_actual, 64'hFFFF_FFFF_FFFF_FFFC);

        // Asynchronous reset mid-run with a non-empty stack
        step(1'b0, 1'b1, 64'h500, 1'b1, 1'b0, 1'b1);
        go(1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("rst1");
        model_reset();
        #1;
        rst = 1'b0;
        go(1'b1);
        check_val("rst1_first", bus.fetch_addr, 64'h0);
        step(1'b0, 1'b1, 64'h777, 1'b0, 1'b1, 1'b0);
        check_val("rst1_ret", bus.fetch_addr, 64'h777);
        go(1'b1);
        go(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
